// File: rtl/conv3x3_stream_if.sv
// Pixel stream bundle for conv3x3_stream: input pixel with framing and kernel
// select, and the filtered output stream with the mode currently in effect.
interface conv3x3_stream_if #(
  parameter int DATA_W = 12
);
  logic [DATA_W-1:0] iDATA;
  logic              iDVAL;
  logic              iSOF;
  logic [2:0]        iMODE;
  logic [DATA_W-1:0] oDATA;
  logic              oDVAL;
  logic [2:0]        oMODE;

  modport master (output iDATA, iDVAL, iSOF, iMODE, input oDATA, oDVAL, oMODE);
  modport slave  (input iDATA, iDVAL, iSOF, iMODE, output oDATA, oDVAL, oMODE);
endinterface

// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution with two internal line buffers, runtime kernel select
// (pass, Sobel X/Y, |Gx|+|Gy|, Gaussian), border masking and saturation; 3-stage pipe.
module conv3x3_stream #(
  parameter int DATA_W = 12,
  parameter int LINE_W = 640,
  parameter int CNT_W  = 11
) (
  input  logic             iCLK,
  input  logic             iRST,
  conv3x3_stream_if.slave  bus
);
  localparam int IW = DATA_W + 4;
  localparam int AW = $clog2(LINE_W);
  localparam logic [DATA_W-1:0] PIX_MAX  = {DATA_W{1'b1}};
  localparam logic [CNT_W-1:0]  COL_LAST = CNT_W'(LINE_W - 1);
  localparam logic [2:0] MODE_SOBX  = 3'd1;
  localparam logic [2:0] MODE_SOBY  = 3'd2;
  localparam logic [2:0] MODE_MAG   = 3'd3;
  localparam logic [2:0] MODE_GAUSS = 3'd4;

  function automatic logic signed [IW-1:0] ext(input logic [DATA_W-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  function automatic logic [IW-1:0] zx(input logic [DATA_W-1:0] p);
    return {4'b0000, p};
  endfunction

  function automatic logic [IW-1:0] absVal(input logic signed [IW-1:0] v);
    return v[IW-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [DATA_W-1:0] sat(input logic [IW-1:0] v);
    return (v > zx(PIX_MAX)) ? PIX_MAX : v[DATA_W-1:0];
  endfunction

  logic [CNT_W-1:0]  colR;
  logic [1:0]        rowR;
  logic [2:0]        modeR;
  logic [DATA_W-1:0] lb0 [LINE_W];
  logic [DATA_W-1:0] lb1 [LINE_W];
  logic [DATA_W-1:0] win [3][3];
  logic              v1R, border1R;
  logic [2:0]        mode1R;
  logic              v2R, border2R;
  logic [2:0]        mode2R;
  logic [DATA_W-1:0] centre2R;
  logic [IW-1:0]     gx2R, gy2R, mag2R, gauss2R;
  logic [DATA_W-1:0] dataR;
  logic              dvalR;

  logic [CNT_W-1:0]     colEff;
  logic [1:0]           rowEff;
  logic [AW-1:0]        lbIdx;
  logic [DATA_W-1:0]    lb0Rd, lb1Rd;
  logic                 border;
  logic signed [IW-1:0] gx, gy;
  logic [IW-1:0]        gsum;
  logic [DATA_W-1:0]    result;

  // An accepted start-of-frame pixel is treated as position (0,0).
  assign colEff = bus.iSOF ? {CNT_W{1'b0}} : colR;
  assign rowEff = bus.iSOF ? 2'd0 : rowR;
  assign lbIdx  = colEff[AW-1:0];
  assign lb0Rd  = lb0[lbIdx];
  assign lb1Rd  = lb1[lbIdx];
  assign border = (rowEff < 2'd2) || (colEff < CNT_W'(2));

  // Line buffers: buffer 0 holds the previous row, buffer 1 the row before; never cleared.
  always_ff @(posedge iCLK) begin
    if (bus.iDVAL && !iRST) begin
      lb0[lbIdx] <= bus.iDATA;
      lb1[lbIdx] <= lb0Rd;
    end
  end

  // Position counters, mode shadow and S1 window, all advancing only on accepted pixels.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      colR     <= {CNT_W{1'b0}};
      rowR     <= 2'd0;
      modeR    <= 3'd0;
      v1R      <= 1'b0;
      border1R <= 1'b0;
      mode1R   <= 3'd0;
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          win[r][c] <= {DATA_W{1'b0}};
        end
      end
    end else begin
      v1R <= bus.iDVAL;
      if (bus.iDVAL) begin
        if (colEff == COL_LAST) begin
          colR <= {CNT_W{1'b0}};
          rowR <= (rowEff == 2'd2) ? 2'd2 : rowEff + 2'd1;
        end else begin
          colR <= colEff + CNT_W'(1'b1);
          rowR <= rowEff;
        end
        if (bus.iSOF) begin
          modeR <= bus.iMODE;
        end
        mode1R   <= bus.iSOF ? bus.iMODE : modeR;
        border1R <= border;
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= lb1Rd;
        win[1][2] <= lb0Rd;
        win[2][2] <= bus.iDATA;
      end
    end
  end

  assign gx = (ext(win[0][2]) + (ext(win[1][2]) <<< 1'd1) + ext(win[2][2]))
            - (ext(win[0][0]) + (ext(win[1][0]) <<< 1'd1) + ext(win[2][0]));
  assign gy = (ext(win[2][0]) + (ext(win[2][1]) <<< 1'd1) + ext(win[2][2]))
            - (ext(win[0][0]) + (ext(win[0][1]) <<< 1'd1) + ext(win[0][2]));
  assign gsum = zx(win[0][0]) + (zx(win[0][1]) << 1'd1) + zx(win[0][2])
              + (zx(win[1][0]) << 1'd1) + (zx(win[1][1]) << 2'd2) + (zx(win[1][2]) << 1'd1)
              + zx(win[2][0]) + (zx(win[2][1]) << 1'd1) + zx(win[2][2]);

  // S2: absolute gradients, magnitude and Gaussian sum, with the pixel's tags.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      v2R      <= 1'b0;
      border2R <= 1'b0;
      mode2R   <= 3'd0;
      centre2R <= {DATA_W{1'b0}};
      gx2R     <= {IW{1'b0}};
      gy2R     <= {IW{1'b0}};
      mag2R    <= {IW{1'b0}};
      gauss2R  <= {IW{1'b0}};
    end else begin
      v2R      <= v1R;
      border2R <= border1R;
      mode2R   <= mode1R;
      centre2R <= win[1][1];
      gx2R     <= absVal(gx);
      gy2R     <= absVal(gy);
      mag2R    <= absVal(gx) + absVal(gy);
      gauss2R  <= gsum >> 3'd4;
    end
  end

  // S3 kernel select with saturation; border pixels are forced to zero.
  always_comb begin
    result = {DATA_W{1'b0}};
    if (border2R) begin
      result = {DATA_W{1'b0}};
    end else begin
      case (mode2R)
        MODE_SOBX:  result = sat(gx2R);
        MODE_SOBY:  result = sat(gy2R);
        MODE_MAG:   result = sat(mag2R);
        MODE_GAUSS: result = sat(gauss2R);
        default:    result = centre2R;
      endcase
    end
  end

  // S3 output register.
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      dataR <= {DATA_W{1'b0}};
      dvalR <= 1'b0;
    end else begin
      dataR <= v2R ? result : {DATA_W{1'b0}};
      dvalR <= v2R;
    end
  end

  assign bus.oDATA = dataR;
  assign bus.oDVAL = dvalR;
  assign bus.oMODE = modeR;
endmodule
